// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: PC-next select encoding, FSM states
// and a small helper used to size the internal down-counters.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        STEP_FORWARD                = 2'd0,
        JUMP_TO_CALCULATED_REGISTER = 2'd1,
        JUMP_TO_LABEL               = 2'd2
    } PC_Next_Select_Case;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } seq_state_e;

    // Bits needed to hold the values 0..max_val, never less than one bit.
    function automatic int counter_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the execute/hazard units (master) and the fetch sequencer
// (slave). Requests flow master->slave, fetch controls and perf counters
// flow slave->master.
interface fetch_sequencer_if #(
    parameter int CNT_W = 32
);
    import fetch_sequencer_pkg::*;

    logic               stall_req;
    logic               jalr_taken;
    logic               label_taken;
    logic               halt_req;
    logic               resume;

    PC_Next_Select_Case pc_sel;
    logic               pc_en;
    logic               flush_if_id;
    logic               flush_id_ex;
    logic               halted;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   redirect_cnt;

    modport master (
        output stall_req, jalr_taken, label_taken, halt_req, resume,
        input  pc_sel, pc_en, flush_if_id, flush_id_ex, halted,
               stall_cnt, redirect_cnt
    );

    modport slave (
        input  stall_req, jalr_taken, label_taken, halt_req, resume,
        output pc_sel, pc_en, flush_if_id, flush_id_ex, halted,
               stall_cnt, redirect_cnt
    );

endinterface

// File: rtl/fetch_seq_perf.sv
// Pair of saturating performance counters for the fetch sequencer: cycles in
// which a hazard stall was applied and redirects that were accepted.
module fetch_seq_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_inc,
    input  logic             redirect_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    // Stall cycle counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Accepted redirect counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_cnt <= '0;
        end else if (redirect_inc && (redirect_cnt != {CNT_W{1'b1}})) begin
            redirect_cnt <= redirect_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: picks the PC-next source, the PC write enable and the
// IF/ID and ID/EX squashes each cycle. Arbitrates execute redirects, halt and
// hazard stalls, and keeps fetch quiet for a boot window after reset.
// Optional build macro FETCH_SEQ_PERF_EN adds saturating stall/redirect
// counters; without it both counter outputs are constant zero.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int BOOT_WAIT    = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.slave  bus
);

    localparam int BOOT_W  = counter_width(BOOT_WAIT);
    localparam int FLUSH_W = counter_width(FLUSH_CYCLES);

    localparam logic [BOOT_W-1:0]  BOOT_LOAD  = BOOT_W'(BOOT_WAIT);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

    // With no boot window the first cycle after reset release is already RUN;
    // the reset override below still keeps fetch quiet while rst_n is low.
    localparam seq_state_e RESET_STATE = (BOOT_WAIT == 0) ? RUN : BOOT;

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [BOOT_W-1:0]  boot_cnt_q;
    logic [BOOT_W-1:0]  boot_cnt_d;
    logic [FLUSH_W-1:0] flush_cnt_q;
    logic [FLUSH_W-1:0] flush_cnt_d;
    logic               halted_q;

    logic               redirect;
    PC_Next_Select_Case redirect_sel;
    PC_Next_Select_Case pc_sel_c;
    logic               pc_en_c;
    logic               flush_if_id_c;
    logic               flush_id_ex_c;

    logic [CNT_W-1:0]   stall_cnt_w;
    logic [CNT_W-1:0]   redirect_cnt_w;

    assign redirect     = bus.jalr_taken | bus.label_taken;
    assign redirect_sel = bus.jalr_taken ? JUMP_TO_CALCULATED_REGISTER : JUMP_TO_LABEL;

    // Next-state and zero-latency fetch controls from current state and requests.
    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        pc_sel_c      = STEP_FORWARD;
        pc_en_c       = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;

        case (state_q)
            BOOT: begin
                flush_if_id_c = 1'b1;
                flush_id_ex_c = 1'b1;
                if (boot_cnt_q <= BOOT_W'(1)) begin
                    boot_cnt_d = '0;
                    state_d    = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - BOOT_W'(1);
                end
            end

            RUN, FLUSH: begin
                if (redirect) begin
                    pc_sel_c      = redirect_sel;
                    pc_en_c       = 1'b1;
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d     = RUN;
                        flush_cnt_d = '0;
                    end
                end else if (state_q == FLUSH) begin
                    // Stall/halt here come from squashed instructions, so skip them.
                    pc_en_c       = 1'b1;
                    flush_if_id_c = 1'b1;
                    if (flush_cnt_q <= FLUSH_W'(1)) begin
                        flush_cnt_d = '0;
                        state_d     = RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                    end
                end else if (bus.halt_req) begin
                    state_d = HALT;
                end else if (!bus.stall_req) begin
                    pc_en_c = 1'b1;
                end
            end

            HALT: begin
                if (bus.resume) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        if (!rst_n) begin
            pc_sel_c      = STEP_FORWARD;
            pc_en_c       = 1'b0;
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
        end
    end

    // State, boot/flush counters and the registered halted flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            boot_cnt_q  <= BOOT_LOAD;
            flush_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            halted_q    <= (state_d == HALT);
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    logic stall_apply;
    logic redirect_accept;

    assign stall_apply     = (state_q == RUN) && !redirect && !bus.halt_req && bus.stall_req;
    assign redirect_accept = ((state_q == RUN) || (state_q == FLUSH)) && redirect;

    fetch_seq_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_inc    (stall_apply),
        .redirect_inc (redirect_accept),
        .stall_cnt    (stall_cnt_w),
        .redirect_cnt (redirect_cnt_w)
    );
`else
    assign stall_cnt_w    = {CNT_W{1'b0}};
    assign redirect_cnt_w = {CNT_W{1'b0}};
`endif

    assign bus.pc_sel       = pc_sel_c;
    assign bus.pc_en        = pc_en_c;
    assign bus.flush_if_id  = flush_if_id_c;
    assign bus.flush_id_ex  = flush_id_ex_c;
    assign bus.halted       = halted_q;
    assign bus.stall_cnt    = stall_cnt_w;
    assign bus.redirect_cnt = redirect_cnt_w;

endmodule
